// File: rtl/i2s_tx_pkg.sv
// Shared state encoding and default geometry for the I2S transmit path.
package i2s_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_SLOT_WIDTH = 32;
  localparam int DEF_CLK_DIV    = 4;

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: sclk toggles every CLK_DIV clk cycles while not cleared.
// Ticks are combinational and flag the cycle whose closing edge toggles sclk.
module i2s_sclk_gen
  import i2s_tx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap      = ~clear & (cnt == CNT_LAST);
  assign rise_tick = wrap & ~sclk;
  assign fall_tick = wrap & sclk;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: one-deep stereo holding register feeding MSB-first slot shifters.
// sample_ready drops while the holding register is full; frames run back to back while enabled.
module i2s_tx_serializer
  import i2s_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [DATA_WIDTH-1:0] sample_left,
  input  logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sclk,
  output logic                  ws,
  output logic                  sd,
  output logic                  underrun,
  output logic                  busy
);

  localparam int PAD   = SLOT_WIDTH - DATA_WIDTH;
  localparam int BIT_W = $clog2(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_WIDTH - 1);

  i2s_state_t            state;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;
  logic [SLOT_WIDTH-1:0] left_sh;
  logic [SLOT_WIDTH-1:0] right_sh;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  slot_end;
  logic                  idle;
  logic                  rise_tick;
  logic                  fall_tick;
  logic                  accept;
  logic                  frame_end;
  logic                  load;

  assign idle         = (state == IDLE);
  assign busy         = ~idle;
  assign sample_ready = ~hold_full;
  assign accept       = sample_valid & ~hold_full;
  assign frame_end    = (state == RIGHT) & fall_tick & slot_end;
  assign load         = enable & (idle | frame_end);

  i2s_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (idle),
    .sclk     (sclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ws         <= 1'b0;
      sd         <= 1'b0;
      underrun   <= 1'b0;
      hold_full  <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
      left_sh    <= '0;
      right_sh   <= '0;
      bit_cnt    <= '0;
      slot_end   <= 1'b0;
    end else begin
      underrun <= load & ~hold_full;

      // A transfer reads the old holding content before a same-cycle accept overwrites it.
      if (accept) begin
        hold_left  <= sample_left;
        hold_right <= sample_right;
        hold_full  <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      // Slot-end is resolved on the rise so the fall tick only has to consult a flop.
      if (rise_tick) slot_end <= (bit_cnt == LAST_BIT);

      unique case (state)
        IDLE: begin
          if (enable) begin
            state    <= LEFT;
            ws       <= 1'b0;
            sd       <= 1'b0;
            bit_cnt  <= '0;
            slot_end <= 1'b0;
          end
        end
        LEFT: begin
          if (fall_tick) begin
            sd      <= left_sh[SLOT_WIDTH-1];
            left_sh <= left_sh << 1;
            if (slot_end) begin
              state   <= RIGHT;
              ws      <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RIGHT: begin
          if (fall_tick) begin
            sd       <= right_sh[SLOT_WIDTH-1];
            right_sh <= right_sh << 1;
            if (slot_end) begin
              bit_cnt <= '0;
              ws      <= 1'b0;
              if (enable) begin
                state <= LEFT;
              end else begin
                state <= IDLE;
                sd    <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        left_sh  <= hold_full ? (SLOT_WIDTH'(hold_left) << PAD) : '0;
        right_sh <= hold_full ? (SLOT_WIDTH'(hold_right) << PAD) : '0;
      end
    end
  end

endmodule
